// File: rtl/prog_loader_pkg.sv
// Shared types and defaults for the program loader and the execution core it feeds.
// The checksum state is only reachable when PROG_LOADER_CHECKSUM_EN is defined.
package prog_loader_pkg;

  localparam int unsigned MAX_WORDS_DEF = 15;
  localparam logic [7:0]  SYNC_BYTE_DEF = 8'hA5;

  typedef logic [15:0] word_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_HI,
    ST_LO,
    ST_CSUM,
    ST_COMMIT,
    ST_ABORT
  } state_e;

  function automatic logic len_ok(input logic [7:0] len, input int unsigned max_words);
    return (len != 8'd0) && (32'(len) <= max_words);
  endfunction

endpackage

// File: rtl/prog_loader_timeout.sv
// Inter-byte idle timer: down-counter reloaded on clear or while disabled, with a
// registered expire flag that is high in the cycle TIMEOUT_CYCLES-1 cycles after the last clear.
module loader_timeout #(
  parameter int unsigned CYCLES = 50_000_000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);
  localparam int unsigned W = (CYCLES > 2) ? $clog2(CYCLES) : 1;

  logic [W-1:0] cnt_q;
  logic         expire_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i || !en_i) begin
      cnt_q    <= W'(CYCLES - 1);
      expire_q <= 1'b0;
    end else begin
      if (cnt_q != '0) cnt_q <= cnt_q - W'(1);
      expire_q <= (cnt_q == W'(1));
    end
  end

  assign expire_o = expire_q;

endmodule

// File: rtl/prog_loader.sv
// Framed byte-stream program loader: assembles words into a shadow buffer and commits
// them atomically to the core's program store. Define PROG_LOADER_CHECKSUM_EN for a trailing XOR byte.
//
//   state  | meaning
//   IDLE   | discard bytes until SYNC_BYTE
//   LEN    | expect word count 1..MAX_WORDS
//   HI     | expect high byte of next word
//   LO     | expect low byte, write shadow word
//   CSUM   | expect XOR of LEN and all data bytes
//   COMMIT | copy shadow to active store, rx_ready low
//   ABORT  | flag error, active store untouched, rx_ready low
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned MAX_WORDS      = MAX_WORDS_DEF,
  parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEF,
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
  parameter int unsigned INIT_LEN       = 3
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] rx_data_i,
  input  logic       rx_valid_i,
  output logic       rx_ready_o,
  output word_t      prog_o [MAX_WORDS],
  output logic [3:0] prog_len_o,
  output logic       core_hold_o,
  output logic       load_done_o,
  output logic       load_err_o
);

  state_e     state_q, state_d;
  logic [3:0] count_q, count_d;
  logic [3:0] idx_q, idx_d;
  logic [7:0] hi_q, hi_d;
  word_t      shadow_q [MAX_WORDS];
  word_t      prog_q [MAX_WORDS];
  logic [3:0] prog_len_q;
  logic       hold_q, done_q, err_q;
  logic       accept, last_word, tmo_en, tmo_expire, shadow_we;

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0] csum_q, csum_d;
`endif

  assign accept    = rx_valid_i && rx_ready_o;
  assign last_word = (idx_q == count_q - 4'd1);

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept && rx_data_i == SYNC_BYTE) state_d = ST_LEN;
      ST_LEN:  if (accept) state_d = len_ok(rx_data_i, MAX_WORDS) ? ST_HI : ST_ABORT;
      ST_HI:   if (accept) state_d = ST_LO;
      ST_LO: begin
        if (accept) begin
`ifdef PROG_LOADER_CHECKSUM_EN
          state_d = last_word ? ST_CSUM : ST_HI;
`else
          state_d = last_word ? ST_COMMIT : ST_HI;
`endif
        end
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      ST_CSUM: if (accept) state_d = (rx_data_i == csum_q) ? ST_COMMIT : ST_ABORT;
`endif
      ST_COMMIT, ST_ABORT: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // a byte accepted in the expiry cycle wins over the timeout
    if (tmo_en && tmo_expire && !accept) state_d = ST_ABORT;
  end

  always_comb begin
    rx_ready_o = 1'b1;
    tmo_en     = 1'b0;
    case (state_q)
      ST_LEN, ST_HI, ST_LO, ST_CSUM: tmo_en     = 1'b1;
      ST_COMMIT, ST_ABORT:           rx_ready_o = 1'b0;
      default: ;
    endcase
  end

  always_comb begin
    count_d   = count_q;
    idx_d     = idx_q;
    hi_d      = hi_q;
    shadow_we = 1'b0;
    if (accept) begin
      case (state_q)
        ST_LEN: begin
          count_d = rx_data_i[3:0];
          idx_d   = 4'd0;
        end
        ST_HI: hi_d = rx_data_i;
        ST_LO: begin
          shadow_we = 1'b1;
          idx_d     = idx_q + 4'd1;
        end
        default: ;
      endcase
    end
  end

`ifdef PROG_LOADER_CHECKSUM_EN
  always_comb begin
    csum_d = csum_q;
    if (accept) begin
      case (state_q)
        ST_LEN:       csum_d = rx_data_i;
        ST_HI, ST_LO: csum_d = csum_q ^ rx_data_i;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) csum_q <= csum_d;
`endif

  always_ff @(posedge clk_i) begin
    count_q <= count_d;
    idx_q   <= idx_d;
    hi_q    <= hi_d;
    if (shadow_we) shadow_q[idx_q] <= {hi_q, rx_data_i};
  end

  // Active store has no reset so the core keeps its preloaded program across rst.
  always_ff @(posedge clk_i) begin
    if (!rst_i && state_q == ST_COMMIT) begin
      for (int unsigned i = 0; i < MAX_WORDS; i++)
        prog_q[i] <= (i < 32'(count_q)) ? shadow_q[i] : '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prog_len_q <= 4'(INIT_LEN);
      hold_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      hold_q <= (state_d != ST_IDLE);
      done_q <= (state_q == ST_COMMIT);
      if (state_q == ST_COMMIT) begin
        prog_len_q <= count_q;
        err_q      <= 1'b0;
      end else if (state_q == ST_ABORT) begin
        err_q <= 1'b1;
      end
    end
  end

  loader_timeout #(.CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (accept),
    .en_i     (tmo_en),
    .expire_o (tmo_expire)
  );

  assign prog_o      = prog_q;
  assign prog_len_o  = prog_len_q;
  assign core_hold_o = hold_q;
  assign load_done_o = done_q;
  assign load_err_o  = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: each frame pushes its expected outcome, and every
// falling edge of core_hold pops one and checks done/err, prog_len and the whole store.
module tb_prog_loader;

  localparam int unsigned TMO  = 16;
  localparam int unsigned NW   = 15;
  localparam logic [7:0]  SYNC = 8'hA5;

  typedef struct packed {
    logic              is_err;
    logic [3:0]        len;
    logic [14:0][15:0] words;
  } exp_t;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [7:0]  rx_data_i = 8'h00;
  logic        rx_valid_i = 1'b0;
  logic        rx_ready_o;
  logic [15:0] prog [NW];
  logic [3:0]  prog_len_o;
  logic        core_hold_o, load_done_o, load_err_o;

  int          n_cmp = 0;
  int          n_bad = 0;
  exp_t        sb[$];
  logic [15:0] model_prog [NW];
  logic [3:0]  model_len = 4'd3;
  logic [15:0] fw [NW];
  int          last_sync_wait;
  bit          mon_skip = 1'b1;
  logic        hold_prev = 1'b0;
  logic        done_prev = 1'b0;

  prog_loader #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .rx_data_i   (rx_data_i),
    .rx_valid_i  (rx_valid_i),
    .rx_ready_o  (rx_ready_o),
    .prog_o      (prog),
    .prog_len_o  (prog_len_o),
    .core_hold_o (core_hold_o),
    .load_done_o (load_done_o),
    .load_err_o  (load_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, output int waited);
    logic rdy;
    repeat (gap) cyc();
    rx_data_i  = b;
    rx_valid_i = 1'b1;
    waited     = 0;
    forever begin
      rdy = rx_ready_o;
      cyc();
      if (rdy) break;
      waited++;
      if (waited > 20) begin
        check_eq("rx_accept_bound", 32'(waited), 32'd0);
        break;
      end
    end
    rx_valid_i = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] len_b, input bit bad_csum, input int gap_idx);
    exp_t       e;
    logic [7:0] cs;
    int         w;
    bit         len_good;
    len_good = (len_b >= 8'd1) && (len_b <= 8'(NW));
    e.is_err = !(len_good && !bad_csum);
    if (!e.is_err) begin
      for (int i = 0; i < NW; i++) model_prog[i] = (i < int'(len_b)) ? fw[i] : 16'h0000;
      model_len = len_b[3:0];
    end
    e.len = model_len;
    for (int i = 0; i < NW; i++) e.words[i] = model_prog[i];
    sb.push_back(e);

    send_byte(SYNC, 0, w);
    last_sync_wait = w;
    check_eq("hold_rise", {31'd0, core_hold_o}, 32'd1);
    send_byte(len_b, 0, w);
    if (len_good) begin
      cs = len_b;
      for (int i = 0; i < int'(len_b); i++) begin
        send_byte(fw[i][15:8], 0, w);
        send_byte(fw[i][7:0], (i == gap_idx) ? int'(TMO) - 1 : 0, w);
        cs = cs ^ fw[i][15:8] ^ fw[i][7:0];
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      send_byte(bad_csum ? (cs ^ 8'h01) : cs, 0, w);
`endif
    end
  endtask

  // Monitor: every frame end (core_hold falling outside reset) consumes one expectation.
  always begin
    exp_t e;
    @(posedge clk_i);
    #1;
    if (!mon_skip && hold_prev && !core_hold_o) begin
      if (sb.size() == 0) begin
        check_eq("sb_unexpected_end", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        check_eq("load_done", {31'd0, load_done_o}, {31'd0, !e.is_err});
        check_eq("load_err", {31'd0, load_err_o}, {31'd0, e.is_err});
        check_eq("prog_len", {28'd0, prog_len_o}, {28'd0, e.len});
        for (int i = 0; i < NW; i++)
          check_eq($sformatf("prog[%0d]", i), {16'd0, prog[i]}, {16'd0, e.words[i]});
      end
    end
    if (load_done_o) check_eq("done_one_cycle", {31'd0, done_prev}, 32'd0);
    hold_prev = core_hold_o;
    done_prev = load_done_o;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    repeat (3) cyc();
    rst_i = 1'b0;
    cyc();
    mon_skip = 1'b0;
    check_eq("rst_prog_len", {28'd0, prog_len_o}, 32'd3);
    check_eq("rst_core_hold", {31'd0, core_hold_o}, 32'd0);
    check_eq("rst_load_done", {31'd0, load_done_o}, 32'd0);
    check_eq("rst_load_err", {31'd0, load_err_o}, 32'd0);
    check_eq("rst_rx_ready", {31'd0, rx_ready_o}, 32'd1);

    // non-sync bytes in IDLE are swallowed without starting a frame
    send_byte(8'h00, 0, w); check_eq("idle_00_hold", {31'd0, core_hold_o}, 32'd0);
    send_byte(8'hFF, 0, w); check_eq("idle_FF_hold", {31'd0, core_hold_o}, 32'd0);
    send_byte(8'hA4, 0, w); check_eq("idle_A4_hold", {31'd0, core_hold_o}, 32'd0);
    check_eq("idle_accept_wait", 32'(w), 32'd0);

    // basic 3-word frame, immediately followed by a 15-word frame whose sync byte is held through COMMIT
    fw[0] = 16'h1234; fw[1] = 16'h5678; fw[2] = 16'h9ABC;
    send_frame(8'h03, 1'b0, -1);
    for (int i = 0; i < NW; i++) fw[i] = {4'(i + 1), 4'(i + 1), 4'(14 - i), 4'(i)};
    send_frame(8'h0F, 1'b0, -1);
    check_eq("sync_held_through_commit", 32'(last_sync_wait), 32'd1);

`ifdef PROG_LOADER_CHECKSUM_EN
    fw[0] = 16'h1234; fw[1] = 16'h5678; fw[2] = 16'h9ABC;
    send_frame(8'h03, 1'b1, -1);
    send_frame(8'h03, 1'b0, -1);
`endif

    // length boundaries, then a good frame to clear the sticky error
    send_frame(8'h00, 1'b0, -1);
    send_frame(8'h10, 1'b0, -1);
    fw[0] = 16'hCAFE;
    send_frame(8'h01, 1'b0, -1);

    // timeout abort: stall after the high byte
    sb.push_back('{is_err: 1'b1, len: model_len, words: {model_prog[14], model_prog[13],
      model_prog[12], model_prog[11], model_prog[10], model_prog[9], model_prog[8],
      model_prog[7], model_prog[6], model_prog[5], model_prog[4], model_prog[3],
      model_prog[2], model_prog[1], model_prog[0]}});
    send_byte(SYNC, 0, w);
    send_byte(8'h02, 0, w);
    send_byte(8'h11, 0, w);
    repeat (TMO) cyc();
    check_eq("tmo_hold_before_expiry", {31'd0, core_hold_o}, 32'd1);
    cyc();
    check_eq("tmo_hold_after", {31'd0, core_hold_o}, 32'd0);
    check_eq("tmo_err_after", {31'd0, load_err_o}, 32'd1);

    // low byte arrives in the expiry cycle and wins; second word carries a sync-valued byte
    fw[0] = 16'hBEEF; fw[1] = 16'hA5A5;
    send_frame(8'h02, 1'b0, 0);
    repeat (3) cyc();

    // reset while in LO: store retained, length back to INIT_LEN
    mon_skip = 1'b1;
    send_byte(SYNC, 0, w);
    send_byte(8'h02, 0, w);
    send_byte(8'h77, 0, w);
    rst_i = 1'b1;
    cyc();
    rst_i = 1'b0;
    check_eq("midrst_hold", {31'd0, core_hold_o}, 32'd0);
    check_eq("midrst_len", {28'd0, prog_len_o}, 32'd3);
    check_eq("midrst_err", {31'd0, load_err_o}, 32'd0);
    check_eq("midrst_ready", {31'd0, rx_ready_o}, 32'd1);
    cyc();
    for (int i = 0; i < NW; i++)
      check_eq($sformatf("midrst_prog[%0d]", i), {16'd0, prog[i]}, {16'd0, model_prog[i]});
    model_len = 4'd3;
    mon_skip = 1'b0;

    fw[0] = 16'h0F0F; fw[1] = 16'hF0F0; fw[2] = 16'h5A5A; fw[3] = 16'h0001;
    send_frame(8'h04, 1'b0, -1);
    repeat (5) cyc();
    check_eq("sb_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
